pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 122 ++++++++++++
 tb/tb_pipe_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline run/step/halt sequencer with hazard control and perf counters
module pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_resume,
  input  logic             i_mode_step,
  input  logic             i_step_pulse,
  input  logic             i_halt_wb,
  input  logic             i_mem_busy,
  input  logic [4:0]       i_id_rs,
  input  logic [4:0]       i_id_rt,
  input  logic [4:0]       i_ex_rt,
  input  logic             i_id_uses_rt,
  input  logic             i_ex_memRead,
  input  logic             i_branch_taken,
  output logic             o_step,
  output logic             o_stall,
  output logic             o_flush,
  output logic             o_halted,
  output logic [1:0]       o_state,
  output logic [CNT_W-1:0] o_cycle_count,
  output logic [CNT_W-1:0] o_stall_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2,
    HALT = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             edge_q, edge_d;
  logic             pend_q, pend_d;
  logic             halted_q, halted_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic step_edge;
  logic adv;
  logic ld_use;
  logic stall;
  logic flush;

  always_comb begin
    step_edge = i_step_pulse & ~edge_q;
    adv       = ((state_q == RUN)  & ~i_mem_busy) |
                ((state_q == STEP) & ~i_mem_busy & (step_edge | pend_q));
    ld_use    = i_ex_memRead & (i_ex_rt != 5'd0) &
                ((i_ex_rt == i_id_rs) | (i_id_uses_rt & (i_ex_rt == i_id_rt)));
    // A taken branch makes the ID instruction wrong-path, so its hazard is moot.
    flush     = adv & i_branch_taken;
    stall     = adv & ld_use & ~i_branch_taken;
  end

  always_comb begin
    state_d     = state_q;
    edge_d      = i_step_pulse;
    pend_d      = pend_q;
    cycle_cnt_d = cycle_cnt_q;
    stall_cnt_d = stall_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (i_start) state_d = i_mode_step ? STEP : RUN;
      end
      RUN: begin
        if (adv && i_halt_wb) state_d = HALT;
        else if (i_mode_step) state_d = STEP;
      end
      STEP: begin
        if (adv) pend_d = 1'b0;
        else if (i_mem_busy && step_edge) pend_d = 1'b1;
        if (adv && i_halt_wb) state_d = HALT;
        else if (!i_mode_step && !pend_q) state_d = RUN;
      end
      HALT: begin
        if (i_resume) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (adv && !(&cycle_cnt_q)) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (state_q == HALT && i_resume) begin
      cycle_cnt_d = '0;
      stall_cnt_d = '0;
    end

    halted_d = (state_d == HALT);
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state_q     <= IDLE;
      edge_q      <= 1'b0;
      pend_q      <= 1'b0;
      halted_q    <= 1'b0;
      cycle_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      edge_q      <= edge_d;
      pend_q      <= pend_d;
      halted_q    <= halted_d;
      cycle_cnt_q <= cycle_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_step        = ~adv;
  assign o_stall       = stall;
  assign o_flush       = flush;
  assign o_halted      = halted_q;
  assign o_state       = state_q;
  assign o_cycle_count = cycle_cnt_q;
  assign o_stall_count = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed scoreboard bench for pipe_ctrl
module tb_pipe_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset, start, resume, mode_step, step_pulse, halt_wb, mem_busy;
  logic [4:0]    id_rs, id_rt, ex_rt;
  logic          id_uses_rt, ex_memread, branch_taken;
  logic          step, stall, flush, halted;
  logic [1:0]    state;
  logic [CW-1:0] cyc, stl;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  pipe_ctrl #(.CNT_W(CW)) dut (
    .clk            (clk),
    .i_reset        (reset),
    .i_start        (start),
    .i_resume       (resume),
    .i_mode_step    (mode_step),
    .i_step_pulse   (step_pulse),
    .i_halt_wb      (halt_wb),
    .i_mem_busy     (mem_busy),
    .i_id_rs        (id_rs),
    .i_id_rt        (id_rt),
    .i_ex_rt        (ex_rt),
    .i_id_uses_rt   (id_uses_rt),
    .i_ex_memRead   (ex_memread),
    .i_branch_taken (branch_taken),
    .o_step         (step),
    .o_stall        (stall),
    .o_flush        (flush),
    .o_halted       (halted),
    .o_state        (state),
    .o_cycle_count  (cyc),
    .o_stall_count  (stl)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s scoreboard empty obs=%0d", tag, obs);
    end else begin
      e = exp_q.pop_front();
      total++;
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s obs=%0d exp=%0d", tag, obs, e);
      end
    end
  endtask

  task automatic clear_hazard();
    ex_memread = 0; ex_rt = 0; id_rs = 0; id_rt = 0; id_uses_rt = 0; branch_taken = 0;
  endtask

  initial begin
    reset = 1; start = 0; resume = 0; mode_step = 0; step_pulse = 0;
    halt_wb = 0; mem_busy = 0;
    clear_hazard();
    tick(); tick();
    reset = 0;
    #1;
    push(1); chk("rst_step", {31'd0, step});
    push(0); chk("rst_stall", {31'd0, stall});
    push(0); chk("rst_flush", {31'd0, flush});
    push(0); chk("rst_halted", {31'd0, halted});
    push(0); chk("rst_state", {30'd0, state});
    push(0); chk("rst_cyc", {28'd0, cyc});

    // free run
    start = 1; mode_step = 0;
    push(1); push(0);
    tick(); start = 0;
    chk("run_state", {30'd0, state});
    chk("run_step", {31'd0, step});
    push(10);
    repeat (10) tick();
    chk("run_cyc10", {28'd0, cyc});

    // load-use and flush priority
    ex_memread = 1; ex_rt = 5; id_rs = 5; #1;
    push(1); chk("lu_stall", {31'd0, stall});
    push(0); chk("lu_flush", {31'd0, flush});
    push(1); push(11);
    tick();
    chk("lu_stl_cnt", {28'd0, stl});
    chk("lu_cyc", {28'd0, cyc});
    ex_rt = 0; id_rs = 0; #1;
    push(0); chk("lu_r0_stall", {31'd0, stall});
    ex_rt = 7; id_rs = 3; id_rt = 7; id_uses_rt = 0; #1;
    push(0); chk("lu_rt_unused", {31'd0, stall});
    id_uses_rt = 1; #1;
    push(1); chk("lu_rt_used", {31'd0, stall});
    branch_taken = 1; #1;
    push(1); chk("fl_flush", {31'd0, flush});
    push(0); chk("fl_stall", {31'd0, stall});
    mem_busy = 1; #1;
    push(1); chk("busy_step", {31'd0, step});
    push(0); chk("busy_flush", {31'd0, flush});
    push(0); chk("busy_stall", {31'd0, stall});
    push(11); push(1);
    tick();
    chk("busy_cyc", {28'd0, cyc});
    chk("busy_stl", {28'd0, stl});
    mem_busy = 0; clear_hazard();

    // enter step mode, two edges while busy, one consumed
    mode_step = 1;
    push(2); push(1); push(12);
    tick();
    chk("st_state", {30'd0, state});
    chk("st_step_idle", {31'd0, step});
    chk("st_cyc", {28'd0, cyc});
    mem_busy = 1; step_pulse = 1; #1;
    push(1); chk("st_busy_step", {31'd0, step});
    tick(); step_pulse = 0; tick();
    step_pulse = 1; tick(); step_pulse = 0; tick();
    push(1); chk("st_pend_step", {31'd0, step});
    push(12); chk("st_pend_cyc", {28'd0, cyc});
    mem_busy = 0; #1;
    push(0); chk("st_release", {31'd0, step});
    push(1); push(13);
    tick();
    chk("st_after1", {31'd0, step});
    chk("st_cyc13", {28'd0, cyc});
    push(1); push(13);
    tick();
    chk("st_after2", {31'd0, step});
    chk("st_drop_cyc", {28'd0, cyc});
    step_pulse = 1; #1;
    push(0); chk("st_edge", {31'd0, step});
    push(1); push(14);
    tick();
    chk("st_held_pulse", {31'd0, step});
    chk("st_cyc14", {28'd0, cyc});
    step_pulse = 0; tick();

    // halt and resume
    step_pulse = 1; halt_wb = 1; #1;
    push(0); chk("h_adv", {31'd0, step});
    push(1); push(3); push(1); push(15);
    tick();
    step_pulse = 0; halt_wb = 0;
    chk("h_halted", {31'd0, halted});
    chk("h_state", {30'd0, state});
    chk("h_step", {31'd0, step});
    chk("h_cyc", {28'd0, cyc});
    start = 1; step_pulse = 1; #1;
    push(1); chk("h_ignore_step", {31'd0, step});
    push(3);
    tick();
    chk("h_ignore_state", {30'd0, state});
    start = 0; step_pulse = 0;
    resume = 1;
    push(0); push(0); push(0); push(0);
    tick(); resume = 0;
    chk("res_state", {30'd0, state});
    chk("res_cyc", {28'd0, cyc});
    chk("res_stl", {28'd0, stl});
    chk("res_halted", {31'd0, halted});

    // step -> run, then saturation
    mode_step = 1; start = 1;
    push(2);
    tick(); start = 0;
    chk("s2r_step_state", {30'd0, state});
    mode_step = 0;
    push(1);
    tick();
    chk("s2r_run_state", {30'd0, state});
    push(15);
    repeat (20) tick();
    chk("sat_cyc", {28'd0, cyc});

    // reset from STEP with pend set
    mode_step = 1; tick();
    mem_busy = 1; step_pulse = 1; tick(); step_pulse = 0;
    reset = 1;
    push(0); push(1); push(0); push(0);
    tick(); reset = 0; mem_busy = 0;
    chk("mr_state", {30'd0, state});
    chk("mr_step", {31'd0, step});
    chk("mr_cyc", {28'd0, cyc});
    chk("mr_stl", {28'd0, stl});
    start = 1;
    push(2); push(1);
    tick(); start = 0;
    chk("mr_step_state", {30'd0, state});
    chk("mr_pend_clear", {31'd0, step});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
